// File: rtl/rf_pkg.sv
// Shared definitions for the receptive-field window scanner.
//   state_t      : scanner FSM states (IDLE / SCAN / FIN)
//   COORD_W      : width of the output row/column coordinates
//   calc_oh/ow   : output feature-map height/width for a given geometry
//   calc_bpr     : beats per output row when LANES windows leave per beat
package rf_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int calc_oh(input int h, input int f, input int s, input int p);
        return (h + 2 * p - f) / s + 1;
    endfunction

    function automatic int calc_ow(input int w, input int f, input int s, input int p);
        return (w + 2 * p - f) / s + 1;
    endfunction

    function automatic int calc_bpr(input int ow, input int lanes);
        return (ow + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/rf_window_extract.sv
// Combinational extraction of one zero-padded D x F x F window.
//   image   : D*H*W pixels, channel-major, then row, then column; pixel
//             (0,0,0) in the most significant slice
//   out_row : output row of this window
//   out_col : output column of this window
//   enable  : when low the whole window reads as zero (unused tail lane)
//   window  : D*F*F pixels ordered channel, window row, window column,
//             first pixel in the most significant slice
module rf_window_extract
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int S          = 2,
    parameter int P          = 0
) (
    input  logic [D*H*W*DATA_WIDTH-1:0] image,
    input  logic [COORD_W-1:0]          out_row,
    input  logic [COORD_W-1:0]          out_col,
    input  logic                        enable,
    output logic [D*F*F*DATA_WIDTH-1:0] window
);

    localparam int NPIX = D * H * W;
    localparam int NWIN = D * F * F;

    // Top-left input coordinate of the window; negative inside the padding.
    logic signed [31:0] base_r;
    logic signed [31:0] base_c;

    assign base_r = $signed(32'(out_row)) * S - P;
    assign base_c = $signed(32'(out_col)) * S - P;

    for (genvar gi = 0; gi < NWIN; gi++) begin : g_pix
        localparam int DI = gi / (F * F);
        localparam int FR = (gi / F) % F;
        localparam int FC = gi % F;

        logic signed [31:0] ir;
        logic signed [31:0] ic;
        logic               inb;
        logic [31:0]        idx;

        assign ir  = base_r + FR;
        assign ic  = base_c + FC;
        assign inb = enable && (ir >= 0) && (ir < H) && (ic >= 0) && (ic < W);
        // Index forced to 0 when outside the image so the select stays in range.
        assign idx = inb ? 32'((DI * H + ir) * W + ic) : 32'd0;

        assign window[(NWIN-1-gi)*DATA_WIDTH +: DATA_WIDTH] =
            inb ? image[(NPIX-1-idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

endmodule

// File: rtl/rf_window_scanner.sv
// Receptive-field window scanner: latches an image on start and streams
// every F x F (x D) window of the zero-padded image, LANES adjacent output
// columns per beat, row-major, over a valid/ready interface.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   start          : begin a scan (only honoured while idle)
//   image          : D*H*W pixels, pixel (0,0,0) in the top slice
//   busy           : high whenever the scanner is not idle
//   rf_valid/ready : beat handshake
//   rf_data        : LANES windows, lane 0 in the top slice
//   rf_lane_valid  : bit n qualifies lane n
//   rf_row, rf_col : output row and lane-0 output column of the beat
//   rf_last        : final beat of the scan
//   done           : one-cycle pulse after the final beat transfers
module rf_window_scanner
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int S          = 2,
    parameter int P          = 0,
    parameter int LANES      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [D*H*W*DATA_WIDTH-1:0]       image,
    output logic                              busy,
    output logic                              rf_valid,
    input  logic                              rf_ready,
    output logic [LANES*D*F*F*DATA_WIDTH-1:0] rf_data,
    output logic [LANES-1:0]                  rf_lane_valid,
    output logic [COORD_W-1:0]                rf_row,
    output logic [COORD_W-1:0]                rf_col,
    output logic                              rf_last,
    output logic                              done
);

    localparam int OH    = calc_oh(H, F, S, P);
    localparam int OW    = calc_ow(W, F, S, P);
    localparam int BPR   = calc_bpr(OW, LANES);
    localparam int WIN_W = D * F * F * DATA_WIDTH;

    state_t                          state_reg;
    logic [D*H*W*DATA_WIDTH-1:0]     img_reg;
    logic [COORD_W-1:0]              grp_reg;   // beat index within the current row

    logic [COORD_W-1:0]              row_next;
    logic [COORD_W-1:0]              col_next;
    logic [COORD_W-1:0]              grp_next;
    logic                            last_next;
    logic [LANES-1:0]                lane_en_next;
    logic [LANES*WIN_W-1:0]          win_next;
    logic [D*H*W*DATA_WIDTH-1:0]     src_image;
    logic                            xfer;

    assign xfer = rf_valid & rf_ready;
    assign busy = (state_reg != ST_IDLE);

    // The first beat is built straight from the port in the same cycle the
    // image is latched; every later beat comes from the latched copy.
    assign src_image = (state_reg == ST_IDLE) ? image : img_reg;

    // Coordinates of the beat to load next: (0,0) when starting, otherwise
    // the successor of the beat currently on the outputs.
    always_comb begin
        row_next = '0;
        col_next = '0;
        grp_next = '0;
        if (state_reg == ST_SCAN) begin
            if (grp_reg == COORD_W'(BPR - 1)) begin
                row_next = rf_row + 1'b1;
                col_next = '0;
                grp_next = '0;
            end else begin
                row_next = rf_row;
                col_next = rf_col + COORD_W'(LANES);
                grp_next = grp_reg + 1'b1;
            end
        end
        last_next = (row_next == COORD_W'(OH - 1)) && (grp_next == COORD_W'(BPR - 1));
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_en_next[gi] = (32'(col_next) + 32'(gi)) < 32'(OW);

        rf_window_extract #(
            .DATA_WIDTH (DATA_WIDTH),
            .D          (D),
            .H          (H),
            .W          (W),
            .F          (F),
            .S          (S),
            .P          (P)
        ) u_extract (
            .image   (src_image),
            .out_row (row_next),
            .out_col (col_next + COORD_W'(gi)),
            .enable  (lane_en_next[gi]),
            .window  (win_next[(LANES-1-gi)*WIN_W +: WIN_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            img_reg       <= '0;
            grp_reg       <= '0;
            rf_valid      <= 1'b0;
            rf_data       <= '0;
            rf_lane_valid <= '0;
            rf_row        <= '0;
            rf_col        <= '0;
            rf_last       <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        img_reg       <= image;
                        state_reg     <= ST_SCAN;
                        rf_valid      <= 1'b1;
                        rf_data       <= win_next;
                        rf_lane_valid <= lane_en_next;
                        rf_row        <= row_next;
                        rf_col        <= col_next;
                        grp_reg       <= grp_next;
                        rf_last       <= last_next;
                    end
                end
                ST_SCAN: begin
                    // Outputs only move on a transfer, so a stalled beat holds.
                    if (xfer) begin
                        if (rf_last) begin
                            state_reg     <= ST_FIN;
                            rf_valid      <= 1'b0;
                            rf_last       <= 1'b0;
                            rf_lane_valid <= '0;
                            done          <= 1'b1;
                        end else begin
                            rf_data       <= win_next;
                            rf_lane_valid <= lane_en_next;
                            rf_row        <= row_next;
                            rf_col        <= col_next;
                            grp_reg       <= grp_next;
                            rf_last       <= last_next;
                        end
                    end
                end
                ST_FIN: begin
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_window_scanner.sv
// Bench for rf_window_scanner: three instances with different geometries
// (6x6 S1 P0, 7x7 S2 P0, 4x4 S1 P1; all F=3, LANES=2). Expected beats are
// queued before each scan; a negedge monitor pops and compares on every
// transfer, and also watches stall stability and the done pulse.
module tb_rf_window_scanner;

    localparam int DW   = 16;
    localparam int BW   = 288;   // LANES*F*F*DW
    localparam int IMGW = 784;   // largest image: 7*7*16

    localparam logic [BW-1:0] HAND_A0 = {
        16'd0, 16'd1, 16'd2, 16'd6, 16'd7, 16'd8, 16'd12, 16'd13, 16'd14,
        16'd1, 16'd2, 16'd3, 16'd7, 16'd8, 16'd9, 16'd13, 16'd14, 16'd15};
    localparam logic [BW-1:0] HAND_B1 = {
        16'd5, 16'd6, 16'd7, 16'd12, 16'd13, 16'd14, 16'd19, 16'd20, 16'd21,
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    localparam logic [BW-1:0] HAND_C0 = {
        16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd0, 16'd5, 16'd6,
        16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7};

    int cfg_h   [3] = '{6, 7, 4};
    int cfg_s   [3] = '{1, 2, 1};
    int cfg_p   [3] = '{0, 0, 1};
    int cfg_oh  [3] = '{4, 3, 4};
    int cfg_ow  [3] = '{4, 3, 4};
    int cfg_bpr [3] = '{2, 2, 2};

    typedef struct {
        int          k;
        logic [15:0] row;
        logic [15:0] col;
        logic [1:0]  lv;
        logic        last;
        logic [BW-1:0] data;
    } beat_t;

    beat_t exp_q[$];

    logic            clk;
    logic            reset;
    logic            start_a    [3];
    logic            ready_a    [3];
    logic [IMGW-1:0] img_a      [3];
    logic            busy_a     [3];
    logic            rf_valid_a [3];
    logic [BW-1:0]   rf_data_a  [3];
    logic [1:0]      rf_lv_a    [3];
    logic [15:0]     rf_row_a   [3];
    logic [15:0]     rf_col_a   [3];
    logic            rf_last_a  [3];
    logic            done_a     [3];

    int n_checks = 0;
    int n_fail   = 0;

    bit            pend_done [3];
    bit            hold_v    [3];
    logic [BW-1:0] held_data [3];
    logic [31:0]   held_rc   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int HH = (gi == 0) ? 6 : (gi == 1) ? 7 : 4;
        localparam int SS = (gi == 1) ? 2 : 1;
        localparam int PP = (gi == 2) ? 1 : 0;

        rf_window_scanner #(
            .DATA_WIDTH (DW),
            .D          (1),
            .H          (HH),
            .W          (HH),
            .F          (3),
            .S          (SS),
            .P          (PP),
            .LANES      (2)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start_a[gi]),
            .image         (img_a[gi][HH*HH*DW-1:0]),
            .busy          (busy_a[gi]),
            .rf_valid      (rf_valid_a[gi]),
            .rf_ready      (ready_a[gi]),
            .rf_data       (rf_data_a[gi]),
            .rf_lane_valid (rf_lv_a[gi]),
            .rf_row        (rf_row_a[gi]),
            .rf_col        (rf_col_a[gi]),
            .rf_last       (rf_last_a[gi]),
            .done          (done_a[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_image(input int k, input int base);
        int h;
        h = cfg_h[k];
        img_a[k] = '0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < h; c++)
                img_a[k][(h*h-1-(r*h+c))*DW +: DW] = 16'(base + r * h + c);
    endtask

    // Reference window content: pixel value base + r*h + c, zero outside.
    function automatic logic [BW-1:0] model_data(input int k, input int base,
                                                 input int row, input int col);
        logic [BW-1:0] d;
        int h, s, p, ir, ic, v, w;
        h = cfg_h[k]; s = cfg_s[k]; p = cfg_p[k];
        d = '0;
        for (int n = 0; n < 2; n++) begin
            if (col + n < cfg_ow[k]) begin
                for (int fr = 0; fr < 3; fr++) begin
                    for (int fc = 0; fc < 3; fc++) begin
                        ir = row * s - p + fr;
                        ic = (col + n) * s - p + fc;
                        v  = (ir >= 0 && ir < h && ic >= 0 && ic < h) ? base + ir * h + ic : 0;
                        w  = n * 9 + fr * 3 + fc;
                        d[(17-w)*DW +: DW] = 16'(v);
                    end
                end
            end
        end
        return d;
    endfunction

    task automatic push_scan(input int k, input int base);
        beat_t e;
        for (int row = 0; row < cfg_oh[k]; row++) begin
            for (int b = 0; b < cfg_bpr[k]; b++) begin
                e.k    = k;
                e.row  = 16'(row);
                e.col  = 16'(b * 2);
                e.lv   = {(b * 2 + 1) < cfg_ow[k], (b * 2) < cfg_ow[k]};
                e.last = (row == cfg_oh[k] - 1) && (b == cfg_bpr[k] - 1);
                e.data = model_data(k, base, row, b * 2);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                pend_done[k] = 1'b0;
                hold_v[k]    = 1'b0;
            end else begin
                if (pend_done[k]) begin
                    chk("done_pulse", BW'(done_a[k]), BW'(1));
                    pend_done[k] = 1'b0;
                end else if (done_a[k]) begin
                    chk("done_spurious", BW'(done_a[k]), BW'(0));
                end
                if (rf_valid_a[k] && hold_v[k]) begin
                    chk("stall_data", rf_data_a[k], held_data[k]);
                    chk("stall_rowcol", BW'({rf_row_a[k], rf_col_a[k]}), BW'(held_rc[k]));
                end
                if (rf_valid_a[k] && !ready_a[k]) begin
                    hold_v[k]    = 1'b1;
                    held_data[k] = rf_data_a[k];
                    held_rc[k]   = {rf_row_a[k], rf_col_a[k]};
                end else begin
                    hold_v[k] = 1'b0;
                end
                if (rf_valid_a[k] && ready_a[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", BW'(rf_valid_a[k]), BW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        $display("beat dut=%0d row=%0d col=%0d lv=%b last=%b", k,
                                 rf_row_a[k], rf_col_a[k], rf_lv_a[k], rf_last_a[k]);
                        chk("beat_ctrl",
                            BW'({8'(k), rf_row_a[k], rf_col_a[k], rf_lv_a[k], rf_last_a[k]}),
                            BW'({8'(e.k), e.row, e.col, e.lv, e.last}));
                        chk("beat_data", rf_data_a[k], e.data);
                        if (rf_last_a[k]) pend_done[k] = 1'b1;
                    end
                end
            end
        end
    end

    // One scan on instance k. stall_at/stall_len hold rf_ready low on a beat,
    // rst_after aborts with reset after that many transfers, dist_base >= 0
    // rewrites the image and re-pulses start mid-scan.
    task automatic run_scan(input int k, input int stall_at, input int stall_len,
                            input int rst_after, input int dist_base);
        int xfers   = 0;
        int stalled = 0;
        bit done_seen = 1'b0;
        bit xfer;
        @(posedge clk); #1;
        start_a[k] = 1'b1;
        ready_a[k] = 1'b1;
        @(posedge clk); #1;
        start_a[k] = 1'b0;
        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            ready_a[k] = !(xfers == stall_at && stalled < stall_len);
            if (!ready_a[k]) stalled++;
            if (dist_base >= 0 && cyc == 2) begin
                set_image(k, dist_base);
                start_a[k] = 1'b1;
            end else begin
                start_a[k] = 1'b0;
            end
            xfer = rf_valid_a[k] && ready_a[k];
            @(posedge clk); #1;
            if (xfer) xfers++;
            if (rst_after >= 0 && xfers == rst_after) begin
                reset      = 1'b1;
                ready_a[k] = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("abort_valid", BW'(rf_valid_a[k]), BW'(0));
                chk("abort_busy", BW'(busy_a[k]), BW'(0));
                chk("abort_rowcol", BW'({rf_row_a[k], rf_col_a[k]}), BW'(0));
                exp_q.delete();
                return;
            end
            if (done_a[k]) done_seen = 1'b1;
        end
        start_a[k] = 1'b0;
        ready_a[k] = 1'b0;
        chk("scan_done_seen", BW'(done_seen), BW'(1));
        @(posedge clk); #1;
        chk("idle_after_done", BW'(busy_a[k]), BW'(0));
        @(posedge clk); #1;
        chk("queue_drained", BW'(exp_q.size()), BW'(0));
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            ready_a[k] = 1'b0;
            img_a[k]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ctrl",
                BW'({rf_valid_a[k], busy_a[k], done_a[k], rf_last_a[k], rf_lv_a[k],
                     rf_row_a[k], rf_col_a[k]}), BW'(0));
            chk("reset_data", rf_data_a[k], '0);
        end

        // 6x6, pixel = r*6+c: 8 beats, hand-checked first beat
        set_image(0, 0);
        push_scan(0, 0);
        exp_q[0].data = HAND_A0;
        run_scan(0, -1, 0, -1, -1);

        // 7x7 stride 2: OW=3, second beat of each row has one live lane
        set_image(1, 1);
        push_scan(1, 1);
        exp_q[1].col  = 16'd2;
        exp_q[1].lv   = 2'b01;
        exp_q[1].data = HAND_B1;
        run_scan(1, -1, 0, -1, -1);

        // 4x4 with one pixel of padding: window (0,0) straddles the border
        set_image(2, 1);
        push_scan(2, 1);
        exp_q[0].data = HAND_C0;
        run_scan(2, -1, 0, -1, -1);

        // Back-pressure: rf_ready low for 5 cycles on beat 3
        set_image(0, 100);
        push_scan(0, 100);
        run_scan(0, 3, 5, -1, -1);

        // Reset after 3 transfers, then a clean restart from (0,0)
        set_image(0, 0);
        push_scan(0, 0);
        run_scan(0, -1, 0, 3, -1);
        set_image(0, 7);
        push_scan(0, 7);
        run_scan(0, -1, 0, -1, -1);

        // Image rewrite and extra start mid-scan must not disturb the scan
        set_image(0, 3);
        push_scan(0, 3);
        run_scan(0, -1, 0, -1, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
